// File: rtl/regfile_mp.sv
// Multi-read-port register file with per-register pending bits for RAW hazard
// detection; combinational reads with optional same-cycle write forwarding.
module regfile_mp #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3,
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_R0  = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       claim_en,
  input  logic [ADDR_W-1:0]          claim_addr,
  output logic [NUM_REGS-1:0]        pending
);

  logic [DATA_W-1:0]   regs_reg [NUM_REGS];
  logic [NUM_REGS-1:0] pending_reg;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_REGS-1:0] wr_hit;
  logic [NUM_REGS-1:0] claim_hit;

  // Address decode per register; out-of-range addresses simply match nothing.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (ZERO_R0 != 0 && gi == 0) begin : g_zero
        assign wr_hit[gi]    = 1'b0;
        assign claim_hit[gi] = 1'b0;
      end else begin : g_live
        assign wr_hit[gi]    = wr_en && (wr_addr == ADDR_W'(gi));
        assign claim_hit[gi] = claim_en && (claim_addr == ADDR_W'(gi));
      end
      // A new claim outranks the retiring producer's clear.
      assign pending_next[gi] = claim_hit[gi] | (pending_reg[gi] & ~wr_hit[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs_reg[r] <= '0;
      end
      pending_reg <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (wr_hit[r]) begin
          regs_reg[r] <= wr_data;
        end
      end
      pending_reg <= pending_next;
    end
  end

  assign pending = pending_reg;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data_mux;
      logic              busy_mux;
      logic              addr_valid;
      logic              bypass_hit;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      always_comb begin
        data_mux   = '0;
        busy_mux   = 1'b0;
        addr_valid = 1'b0;
        for (int r = 0; r < NUM_REGS; r++) begin
          if (addr == ADDR_W'(r)) begin
            data_mux   = regs_reg[r];
            busy_mux   = pending_reg[r];
            addr_valid = 1'b1;
          end
        end
      end

      // R0 stays zero even when the write port targets it.
      assign bypass_hit = (BYPASS != 0) && wr_en && (wr_addr == addr) && addr_valid &&
                          !((ZERO_R0 != 0) && (addr == '0));

      assign rd_data[gi*DATA_W +: DATA_W] = bypass_hit ? wr_data : data_mux;
      assign rd_busy[gi]                  = bypass_hit ? 1'b0 : busy_mux;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: four parameter variants share one stimulus
// stream; expectations are queued by the driver and checked by a monitor.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        reset;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [5:0]  rd_addr;
  logic        claim_en;
  logic [2:0]  claim_addr;

  logic [31:0] rdd  [4];
  logic [1:0]  rbs  [4];
  logic [7:0]  pend [4];
  logic [5:0]  pend2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    int          dut;
    int          kind;
    int          port;
    logic [15:0] exp;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) d0 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[0]), .rd_busy(rbs[0]),
    .claim_en(claim_en), .claim_addr(claim_addr), .pending(pend[0]));

  regfile_mp #(.BYPASS(0)) d1 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[1]), .rd_busy(rbs[1]),
    .claim_en(claim_en), .claim_addr(claim_addr), .pending(pend[1]));

  regfile_mp #(.NUM_REGS(6)) d2 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[2]), .rd_busy(rbs[2]),
    .claim_en(claim_en), .claim_addr(claim_addr), .pending(pend2));

  regfile_mp #(.ZERO_R0(1)) d3 (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr(rd_addr), .rd_data(rdd[3]), .rd_busy(rbs[3]),
    .claim_en(claim_en), .claim_addr(claim_addr), .pending(pend[3]));

  assign pend[2] = {2'b00, pend2};

  // kind 0 = rd_data, 1 = rd_busy, 2 = pending vector
  function automatic logic [15:0] actual(int d, int k, int p);
    case (k)
      0:       return rdd[d][p*16 +: 16];
      1:       return {15'b0, rbs[d][p]};
      default: return {8'b0, pend[d]};
    endcase
  endfunction

  task automatic expect_v(string n, int d, int k, int p, logic [15:0] e);
    exp_t x;
    x.name = n; x.dut = d; x.kind = k; x.port = p; x.exp = e;
    q.push_back(x);
  endtask

  // Advance one edge, then apply the next cycle's inputs.
  task automatic step(logic rst, logic we, logic [2:0] wa, logic [15:0] wd,
                      logic ce, logic [2:0] ca, logic [2:0] ra0, logic [2:0] ra1);
    @(posedge clk);
    #1;
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca; rd_addr = {ra1, ra0};
  endtask

  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t x;
      logic [15:0] a;
      x = q.pop_front();
      a = actual(x.dut, x.kind, x.port);
      checks++;
      if (a !== x.exp) begin
        errors++;
        $display("FAIL %s dut%0d: got %h expected %h", x.name, x.dut, a, x.exp);
      end else begin
        $display("ok   %s dut%0d: %h", x.name, x.dut, a);
      end
    end
  end

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0; rd_addr = '0;
    repeat (2) @(posedge clk);

    // Reset state
    step(0, 0, 0, 16'h0000, 0, 0, 3'd0, 3'd3);
    expect_v("rst_pending", 0, 2, 0, 16'h0000);
    expect_v("rst_rd0", 0, 0, 0, 16'h0000);
    expect_v("rst_busy0", 0, 1, 0, 16'h0000);

    // R3 = BEEF, then reset with a competing write and claim
    step(0, 1, 3'd3, 16'hBEEF, 0, 0, 3'd3, 3'd3);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd3, 3'd3);
    expect_v("r3_before_rst", 0, 0, 0, 16'hBEEF);
    expect_v("r3_before_rst", 1, 0, 0, 16'hBEEF);
    step(1, 1, 3'd3, 16'h1111, 1, 3'd5, 3'd3, 3'd3);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd3, 3'd5);
    expect_v("r3_after_rst", 0, 0, 0, 16'h0000);
    expect_v("pend_after_rst_claim", 0, 2, 0, 16'h0000);
    expect_v("busy_after_rst_claim", 0, 1, 1, 16'h0000);

    // R5 = 1234, both ports reading R5
    step(0, 1, 3'd5, 16'h1234, 0, 0, 3'd5, 3'd5);
    expect_v("byp_r5_p1", 0, 0, 1, 16'h1234);
    expect_v("nobyp_r5_old", 1, 0, 1, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd5, 3'd5);
    expect_v("r5_p0", 0, 0, 0, 16'h1234);
    expect_v("r5_p1", 0, 0, 1, 16'h1234);
    expect_v("r5_busy0", 0, 1, 0, 16'h0000);
    expect_v("r5_busy1", 0, 1, 1, 16'h0000);
    expect_v("nobyp_r5_new", 1, 0, 1, 16'h1234);

    // Bypass on port 1 against an existing old value
    step(0, 1, 3'd2, 16'h0BAD, 0, 0, 3'd0, 3'd0);
    step(0, 1, 3'd2, 16'hA5A5, 0, 0, 3'd0, 3'd2);
    expect_v("byp_r2", 0, 0, 1, 16'hA5A5);
    expect_v("nobyp_r2_old", 1, 0, 1, 16'h0BAD);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd0, 3'd2);
    expect_v("nobyp_r2_new", 1, 0, 1, 16'hA5A5);

    // Claim R4: invisible in the claim cycle, visible after the edge
    step(0, 0, 0, 16'h0000, 1, 3'd4, 3'd4, 3'd0);
    expect_v("claim_same_busy", 0, 1, 0, 16'h0000);
    expect_v("claim_same_pend", 0, 2, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd4, 3'd0);
    expect_v("claim_pend", 0, 2, 0, 16'h0010);
    expect_v("claim_busy", 0, 1, 0, 16'h0001);
    expect_v("claim_busy", 1, 1, 0, 16'h0001);

    // Producer writes R4 back
    step(0, 1, 3'd4, 16'h0042, 0, 0, 3'd4, 3'd0);
    expect_v("wb_byp_data", 0, 0, 0, 16'h0042);
    expect_v("wb_byp_busy", 0, 1, 0, 16'h0000);
    expect_v("wb_nobyp_busy", 1, 1, 0, 16'h0001);
    expect_v("wb_nobyp_data", 1, 0, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd4, 3'd0);
    expect_v("wb_pend", 0, 2, 0, 16'h0000);
    expect_v("wb_data", 0, 0, 0, 16'h0042);
    expect_v("wb_busy", 0, 1, 0, 16'h0000);

    // Claim and write collide on R6
    step(0, 1, 3'd6, 16'h7777, 1, 3'd6, 3'd6, 3'd0);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd6, 3'd0);
    expect_v("coll_data", 0, 0, 0, 16'h7777);
    expect_v("coll_busy", 0, 1, 0, 16'h0001);
    expect_v("coll_pend", 0, 2, 0, 16'h0040);

    // Address 7 is out of range for the six-register variant
    step(0, 1, 3'd7, 16'hDEAD, 1, 3'd7, 3'd7, 3'd3);
    expect_v("inv_same_data", 2, 0, 0, 16'h0000);
    expect_v("inv_same_busy", 2, 1, 0, 16'h0000);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd7, 3'd5);
    expect_v("inv_data", 2, 0, 0, 16'h0000);
    expect_v("inv_busy", 2, 1, 0, 16'h0000);
    expect_v("inv_pend", 2, 2, 0, 16'h0000);
    expect_v("inv_r5_kept", 2, 0, 1, 16'h1234);
    expect_v("full_r7_pend", 0, 2, 0, 16'h00C0);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd6, 3'd7);
    expect_v("inv_r6_data", 2, 0, 0, 16'h0000);
    expect_v("full_r7_data", 0, 0, 1, 16'hDEAD);

    // R0 hardwired to zero
    step(0, 1, 3'd0, 16'hFFFF, 1, 3'd0, 3'd0, 3'd0);
    expect_v("z_same_data", 3, 0, 0, 16'h0000);
    expect_v("z_same_busy", 3, 1, 0, 16'h0000);
    expect_v("nz_same_data", 0, 0, 0, 16'hFFFF);
    step(0, 0, 0, 16'h0000, 0, 0, 3'd0, 3'd0);
    expect_v("z_data", 3, 0, 0, 16'h0000);
    expect_v("z_busy", 3, 1, 0, 16'h0000);
    expect_v("z_pend", 3, 2, 0, 16'h00C0);
    expect_v("nz_data", 0, 0, 0, 16'hFFFF);
    expect_v("nz_busy", 0, 1, 0, 16'h0001);

    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d entries left expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
Parametrised multi-read-port register file with an integrated scoreboard. It is the operand-fetch storage for the decode stage of the pipelined processor. Writes are synchronous on the rising edge, and there is optional same-cycle write-to-read bypass. Per-register pending bits let decode detect RAW hazards against in-flight producers and stall issue.

Parameters:
DATA_W, 16, register data width in bits
NUM_REGS, 8, number of architectural registers (2..2^ADDR_W)
ADDR_W, 3, register address width
NUM_RD, 2, number of independent read ports (1..4)
BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = no forwarding
ZERO_R0, 0, 1 = register 0 is hardwired to zero

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high; clears registers and pending bits
wr_en  in  1  write-back enable
wr_addr  in  ADDR_W  write-back register address
wr_data  in  DATA_W  write-back data
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
rd_busy  out  NUM_RD  1 = port k's register has an outstanding producer
claim_en  in  1  issue marks the destination register as pending
claim_addr  in  ADDR_W  destination register being claimed
pending  out  NUM_REGS  current pending bit vector, registered

Behaviour:
- Storage: NUM_REGS x DATA_W registers, plus NUM_REGS pending bits.
- Reset (rising edge with reset=1):
  - All registers become 0 and all pending bits become 0.
  - reset has priority over wr_en and claim_en in the same cycle.
  - Outputs follow combinationally from the cleared state: rd_data=0, rd_busy=0, pending=0.
- Write:
  - On the rising edge with wr_en=1 and wr_addr valid, regs[wr_addr] takes wr_data and pending[wr_addr] clears.
  - Write latency is one edge.
- Claim:
  - On the rising edge with claim_en=1 and claim_addr valid, pending[claim_addr] is set.
  - If claim and write target the same register in the same cycle, the claim wins: data is written and the pending bit ends at 1, because a new producer has been issued.
  - Claims to distinct registers from a write are independent.
- Reads are combinational, with no read latency.
  - If BYPASS=1, wr_en=1 and wr_addr==rd_addr[k] (valid): rd_data[k]=wr_data and rd_busy[k]=0.
  - Otherwise rd_data[k]=regs[rd_addr[k]] and rd_busy[k]=pending[rd_addr[k]].
  - If BYPASS=0: rd_data[k]=regs[...] (old value) and rd_busy[k]=pending[...] in the write cycle; the new value is visible after the edge.
  - A same-cycle claim does not affect rd_busy until after the edge.
- Invalid address (value >= NUM_REGS):
  - Writes and claims are ignored.
  - Reads return rd_data=0 and rd_busy=0.
- ZERO_R0=1:
  - Reads of address 0 return 0 with busy=0, including when bypass would match.
  - Writes and claims to address 0 are ignored, and pending[0] stays 0.
- Read ports are fully independent. Any number of ports may address the same register in the same cycle.
- No X may propagate: every register has a defined value from the first reset onward.

Test Plan:
- Reset: write 0xBEEF to R3, then assert reset for 1 cycle -> all rd_data=0, pending=0, and R3 reads 0x0000.
- Write/read: write R5=0x1234 with wr_en; next cycle rd_addr port0=5, port1=5 -> both ports read 0x1234 with rd_busy=0.
- Bypass:
  - BYPASS=1: in the cycle wr_en=1, wr_addr=2, wr_data=0xA5A5 with rd_addr port1=2 -> rd_data1=0xA5A5 in that same cycle.
  - BYPASS=0: same stimulus -> rd_data1 shows the old value, and 0xA5A5 the next cycle.
- Scoreboard:
  - claim R4 -> next cycle pending[4]=1 and rd_busy=1 for port0 reading 4.
  - Write R4=0x0042 -> the same cycle shows busy=0 with data 0x0042 (BYPASS=1), and pending[4]=0 after the edge.
- Claim/write collision: claim_en and wr_en both targeting R6 with data 0x7777 -> after the edge R6=0x7777 and pending[6]=1. Separately, reset with claim_en=1 -> pending stays 0.
- Edge cases:
  - NUM_REGS=6: write to addr 7 -> no register changes, and reading 7 returns 0 with busy=0.
  - ZERO_R0=1: write 0xFFFF to R0 -> R0 reads 0 and pending[0]=0.
